// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package adc_seq_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, ACCUM} seq_state_t;

  localparam int MIN_CONV_CYCLES  = 2;
  localparam int SEQ_DATA_W       = 8;
  localparam int SEQ_AVG_MAX_LOG2 = 3;
  localparam int ACC_W            = SEQ_DATA_W + SEQ_AVG_MAX_LOG2;
  localparam int FIFO_CNT_W       = 3;

endpackage

// File: rtl/adc_seq_fifo.sv
// First-word-fall-through result FIFO with occupancy count and drop flag.
module adc_seq_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_bits,
  output logic [CNT_W-1:0]  count,
  output logic              drop
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, do_push, do_pop;

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && out_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && (!full || do_pop);
  assign drop      = push && full && !do_pop;
  assign out_bits  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC sequencer: adc_clock generation, conversion counting, 2^n averaging,
// and result queueing.
//   state   | meaning
//   IDLE    | waiting for start/continuous; adc_clock low
//   CONVERT | toggling adc_clock until the 2C-th (falling) edge samples adc_data
//   ACCUM   | one cycle: count sample, push averaged result when 2^n collected
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DIV_W        = 8,
  parameter int CONV_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int AVG_MAX_LOG2 = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic              cfg_continuous,
  input  logic              cfg_start,
  input  logic [DIV_W-1:0]  cfg_clk_div,
  input  logic [CONV_W-1:0] cfg_conv_cycles,
  input  logic [1:0]        cfg_avg_log2,
  output logic              adc_clock,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_bits,
  output logic [2:0]        fifo_count,
  output logic              busy,
  output logic              overflow,
  input  logic              ovf_clear
);

  localparam int ACC_LW = DATA_W + AVG_MAX_LOG2;
  localparam int TOG_W  = CONV_W + 1;
  localparam int SAMP_W = AVG_MAX_LOG2 + 1;

  seq_state_t        state, next_state;
  logic [DIV_W-1:0]  div_sh, div_cnt;
  logic [CONV_W-1:0] conv_sh, conv_sat;
  logic [1:0]        avg_sh, avg_sat;
  logic [TOG_W-1:0]  tog_cnt;
  logic [SAMP_W-1:0] samp_cnt, samp_target;
  logic [ACC_LW-1:0] acc;
  logic [DATA_W-1:0] push_data;
  logic              start_ok, div_wrap, tog_last, samp_done;
  logic              conv_end, push, fifo_drop;

  assign start_ok    = cfg_enable && (cfg_start || cfg_continuous);
  assign conv_sat    = (cfg_conv_cycles < CONV_W'(MIN_CONV_CYCLES)) ?
                       CONV_W'(MIN_CONV_CYCLES) : cfg_conv_cycles;
  assign avg_sat     = (32'(cfg_avg_log2) > AVG_MAX_LOG2) ? 2'(AVG_MAX_LOG2) : cfg_avg_log2;
  assign div_wrap    = (div_cnt == div_sh);
  assign tog_last    = (tog_cnt == ({conv_sh, 1'b0} - TOG_W'(1)));
  assign samp_target = SAMP_W'(1) << avg_sh;
  assign samp_done   = ((samp_cnt + SAMP_W'(1)) >= samp_target);
  assign push_data   = DATA_W'(acc >> avg_sh);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = CONVERT;
      CONVERT: if (!cfg_enable) next_state = IDLE;
               else if (conv_end) next_state = ACCUM;
      ACCUM:   if (!cfg_enable) next_state = IDLE;
               else if (!samp_done || cfg_continuous) next_state = CONVERT;
               else next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    conv_end = (state == CONVERT) && cfg_enable && div_wrap && tog_last;
    push     = (state == ACCUM) && cfg_enable && samp_done;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_sh    <= '0;
      conv_sh   <= CONV_W'(MIN_CONV_CYCLES);
      avg_sh    <= '0;
      div_cnt   <= '0;
      tog_cnt   <= '0;
      samp_cnt  <= '0;
      acc       <= '0;
      adc_clock <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        CONVERT: begin
          if (!cfg_enable) begin
            div_cnt  <= '0;
            tog_cnt  <= '0;
            samp_cnt <= '0;
            acc      <= '0;
          end else if (div_wrap) begin
            div_cnt <= '0;
            tog_cnt <= tog_cnt + TOG_W'(1);
            if (conv_end) acc <= acc + ACC_LW'(adc_data);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ACCUM: begin
          div_cnt <= '0;
          tog_cnt <= '0;
          if (!cfg_enable || samp_done) begin
            samp_cnt <= '0;
            acc      <= '0;
          end else begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end
        default: begin
          div_cnt  <= '0;
          tog_cnt  <= '0;
          samp_cnt <= '0;
          acc      <= '0;
          // Shadowing keeps a running burst immune to register writes.
          if (start_ok) begin
            div_sh  <= cfg_clk_div;
            conv_sh <= conv_sat;
            avg_sh  <= avg_sat;
          end
        end
      endcase

      if (state == CONVERT && cfg_enable) begin
        if (div_wrap) adc_clock <= ~adc_clock;
      end else begin
        adc_clock <= 1'b0;
      end

      if (fifo_drop)      overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  adc_seq_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FIFO_CNT_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (out_ready),
    .out_valid(out_valid),
    .out_bits (out_bits),
    .count    (fifo_count),
    .drop     (fifo_drop)
  );

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed scenario bench for adc_sequencer; cycle numbers count edges from the start cycle.
module tb_adc_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_enable, cfg_continuous, cfg_start;
  logic [7:0] cfg_clk_div;
  logic [4:0] cfg_conv_cycles;
  logic [1:0] cfg_avg_log2;
  logic       adc_clock;
  logic [7:0] adc_data;
  logic       out_valid, out_ready;
  logic [7:0] out_bits;
  logic [2:0] fifo_count;
  logic       busy, overflow, ovf_clear;

  int n_cmp = 0;
  int n_bad = 0;

  adc_sequencer dut (
    .clock(clock), .reset(reset),
    .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous), .cfg_start(cfg_start),
    .cfg_clk_div(cfg_clk_div), .cfg_conv_cycles(cfg_conv_cycles), .cfg_avg_log2(cfg_avg_log2),
    .adc_clock(adc_clock), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cfg_enable = 1'b1; cfg_continuous = 1'b0; cfg_start = 1'b0;
    cfg_clk_div = 8'd1; cfg_conv_cycles = 5'd9; cfg_avg_log2 = 2'd0;
    adc_data = 8'h00; out_ready = 1'b0; ovf_clear = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({adc_clock, out_valid, out_bits, fifo_count, busy, overflow} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got clk=%b v=%b bits=%h cnt=%0d busy=%b ovf=%b, want all 0",
               adc_clock, out_valid, out_bits, fifo_count, busy, overflow);
    end
  endtask

  task automatic test_single();
    int rises = 0;
    logic prev = 1'b0;
    do_reset();
    adc_data = 8'hA5;
    for (int c = 0; c <= 40; c++) begin
      cfg_start = (c == 0);
      if (adc_clock && !prev) rises++;
      prev = adc_clock;
      if (c == 2 || c == 3 || c == 5 || c == 7) begin
        n_cmp++;
        if (adc_clock !== ((c == 3 || c == 7) ? 1'b1 : 1'b0)) begin
          n_bad++; $display("FAIL single_adc_clock c=%0d: got %b", c, adc_clock);
        end
      end
      if (c == 37) begin
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL single_c37: got valid=%b busy=%b want 0 1", out_valid, busy);
        end
      end
      if (c == 38) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_bits !== 8'hA5 || busy !== 1'b0 || fifo_count !== 3'd1) begin
          n_bad++;
          $display("FAIL single_c38: got valid=%b bits=%h busy=%b cnt=%0d want 1 a5 0 1",
                   out_valid, out_bits, busy, fifo_count);
        end
      end
      tick();
    end
    n_cmp++;
    if (rises !== 9) begin
      n_bad++; $display("FAIL single_rises: got %0d want 9", rises);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_bits !== 8'h00 || fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL single_pop: got valid=%b bits=%h cnt=%0d want 0 00 0",
                        out_valid, out_bits, fifo_count);
    end
  endtask

  task automatic test_average();
    int falls = 0;
    logic prev = 1'b0;
    do_reset();
    cfg_clk_div = 8'd0; cfg_conv_cycles = 5'd2; cfg_avg_log2 = 2'd2;
    for (int c = 0; c <= 24; c++) begin
      cfg_start = (c == 0);
      adc_data = (c <= 4) ? 8'd10 : (c <= 9) ? 8'd20 : (c <= 14) ? 8'd30 : 8'd41;
      if (!adc_clock && prev) falls++;
      prev = adc_clock;
      if (c == 5 || c == 10 || c == 15) begin
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          n_bad++; $display("FAIL avg_midway c=%0d: got busy=%b valid=%b want 1 0", c, busy, out_valid);
        end
      end
      if (c == 19 || c == 20) begin
        n_cmp++;
        if (adc_clock !== (c == 19 ? 1'b1 : 1'b0)) begin
          n_bad++; $display("FAIL avg_last_edge c=%0d: got %b", c, adc_clock);
        end
      end
      if (c == 21) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_bits !== 8'h19 || fifo_count !== 3'd1 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL avg_result: got valid=%b bits=%h cnt=%0d busy=%b want 1 19 1 0",
                   out_valid, out_bits, fifo_count, busy);
        end
      end
      tick();
    end
    n_cmp++;
    if (falls !== 8) begin
      n_bad++; $display("FAIL avg_falls: got %0d want 8", falls);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_clk_div = 8'd0; cfg_conv_cycles = 5'd2; cfg_avg_log2 = 2'd0;
    cfg_continuous = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      adc_data  = 8'(16 + (c - 1) / 5);
      out_ready = (c == 30);
      ovf_clear = (c == 26 || c == 35);
      if (c == 21) begin
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          n_bad++; $display("FAIL ovf_full: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow);
        end
      end
      if (c == 26) begin
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || out_bits !== 8'h10) begin
          n_bad++; $display("FAIL ovf_set: got cnt=%0d ovf=%b head=%h want 4 1 10",
                            fifo_count, overflow, out_bits);
        end
      end
      if (c == 27) begin
        n_cmp++;
        if (overflow !== 1'b0) begin
          n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
      end
      if (c == 31) begin
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || out_bits !== 8'h11) begin
          n_bad++; $display("FAIL ovf_push_pop: got cnt=%0d ovf=%b head=%h want 4 0 11",
                            fifo_count, overflow, out_bits);
        end
      end
      if (c == 36) begin
        n_cmp++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
          n_bad++; $display("FAIL ovf_set_priority: got ovf=%b cnt=%0d want 1 4", overflow, fifo_count);
        end
      end
      tick();
    end
    cfg_continuous = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    adc_data = 8'h3C;
    for (int c = 0; c <= 45; c++) begin
      cfg_start = (c == 0);
      if (c == 7) begin
        n_cmp++;
        if (adc_clock !== 1'b1 || busy !== 1'b1) begin
          n_bad++; $display("FAIL abort_pre: got clk=%b busy=%b want 1 1", adc_clock, busy);
        end
        cfg_enable = 1'b0;
      end
      if (c == 8) begin
        n_cmp++;
        if (busy !== 1'b0 || adc_clock !== 1'b0) begin
          n_bad++; $display("FAIL abort_idle: got busy=%b clk=%b want 0 0", busy, adc_clock);
        end
      end
      if (c == 10) cfg_enable = 1'b1;
      if (c == 45) begin
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
          n_bad++; $display("FAIL abort_nopush: got valid=%b cnt=%0d busy=%b want 0 0 0",
                            out_valid, fifo_count, busy);
        end
      end
      tick();
    end
    for (int c = 0; c <= 38; c++) begin
      cfg_start = (c == 0);
      if (c == 37 || c == 38) begin
        n_cmp++;
        if (out_valid !== (c == 38) || (c == 38 && out_bits !== 8'h3C)) begin
          n_bad++; $display("FAIL abort_restart c=%0d: got valid=%b bits=%h", c, out_valid, out_bits);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_clk_div = 8'd0; cfg_conv_cycles = 5'd2;
    cfg_continuous = 1'b1;
    adc_data = 8'h77;
    for (int c = 0; c < 15; c++) tick();
    n_cmp++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      n_bad++; $display("FAIL resetmid_pre: got cnt=%0d busy=%b want 2 1", fifo_count, busy);
    end
    reset = 1'b0;
    cfg_continuous = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if ({adc_clock, out_valid, out_bits, fifo_count, busy, overflow} !== 15'd0) begin
      n_bad++;
      $display("FAIL resetmid_outputs: got clk=%b v=%b bits=%h cnt=%0d busy=%b ovf=%b, want all 0",
               adc_clock, out_valid, out_bits, fifo_count, busy, overflow);
    end
  endtask

  task automatic test_shadow();
    do_reset();
    adc_data = 8'h5A;
    for (int c = 0; c <= 38; c++) begin
      cfg_start = (c == 0);
      if (c == 5) cfg_clk_div = 8'd3;
      if (c == 7 || c == 9) begin
        n_cmp++;
        if (adc_clock !== (c == 7 ? 1'b1 : 1'b0)) begin
          n_bad++; $display("FAIL shadow_old_period c=%0d: got %b", c, adc_clock);
        end
      end
      if (c == 38) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_bits !== 8'h5A || busy !== 1'b0) begin
          n_bad++; $display("FAIL shadow_first: got valid=%b bits=%h busy=%b want 1 5a 0",
                            out_valid, out_bits, busy);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c <= 74; c++) begin
      cfg_start = (c == 0);
      if (c == 4 || c == 5 || c == 8 || c == 9) begin
        n_cmp++;
        if (adc_clock !== ((c == 5 || c == 8) ? 1'b1 : 1'b0)) begin
          n_bad++; $display("FAIL shadow_new_period c=%0d: got %b", c, adc_clock);
        end
      end
      if (c == 73 || c == 74) begin
        n_cmp++;
        if (out_valid !== (c == 74) || (c == 74 && (out_bits !== 8'h5A || fifo_count !== 3'd1))) begin
          n_bad++; $display("FAIL shadow_latency c=%0d: got valid=%b bits=%h cnt=%0d",
                            c, out_valid, out_bits, fifo_count);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_single();
    test_average();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_shadow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Digital-side controller for the on-chip 8-bit SAR ADC slice.
- Generates the ADC conversion clock (`adc_clock`) from the core clock and counts conversion cycles.
- Captures `adc_data` at the end of each conversion, optionally averages 2^n samples, and queues results in a small FIFO with a valid/ready interface to the SoC MMIO/DMA side.
- Sits inside the Digital block between the register map and the ADC pins `adc_clock` / `adc_data`.

Parameters:
- DATA_W, 8, ADC result width.
- DIV_W, 8, width of the clock-divider setting.
- CONV_W, 5, width of the conversion-cycle count.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).
- AVG_MAX_LOG2, 3, maximum value of log2 of the averaging count.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset
- cfg_enable  in  1  block enable; low aborts any activity
- cfg_continuous  in  1  1 = free-running conversions, 0 = single burst per start
- cfg_start  in  1  one-cycle start pulse; honoured only in IDLE
- cfg_clk_div  in  DIV_W  adc_clock half-period minus 1, in core cycles (D)
- cfg_conv_cycles  in  CONV_W  adc_clock periods per conversion (C); values below 2 are treated as 2
- cfg_avg_log2  in  2  average 2^n samples per result; values above AVG_MAX_LOG2 saturate to it
- adc_clock  out  1  ADC conversion clock
- adc_data  in  DATA_W  ADC result, stable while the last adc_clock falling edge is driven
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_bits  out  DATA_W  FIFO head; 0 when empty
- fifo_count  out  3  entries held (0..FIFO_DEPTH)
- busy  out  1  state != IDLE
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- ovf_clear  in  1  clears overflow

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; adc_clock=0; FIFO empty; out_valid=0; out_bits=0; fifo_count=0; busy=0; overflow=0.
  - Divider, cycle, sample counters and accumulator all cleared.
  - Applies mid-conversion as well; no partial result is pushed.
- FSM states: IDLE, CONVERT, ACCUM.
  - IDLE → CONVERT when cfg_enable && (cfg_start || cfg_continuous).
  - On that transition, latch D, C, n into shadow registers; config changes during a burst are ignored.
- adc_clock generation in CONVERT:
  - Divider counts 0..D; at D it wraps and adc_clock toggles (registered).
  - The k-th toggle occurs at the end of cycle k(D+1), counted from the first CONVERT cycle as cycle 1.
  - adc_clock is held low outside CONVERT.
- Conversion end:
  - In the cycle that produces the 2C-th toggle (falling edge), sample adc_data.
  - Accumulate: acc (DATA_W+3 bits) += adc_data.
  - Then go to ACCUM.
- ACCUM (exactly 1 cycle):
  - Increment the sample counter.
  - If samples < 2^n, go to CONVERT.
  - Otherwise push (acc >> n), truncated to DATA_W, clear acc and the sample counter, then go to CONVERT if cfg_continuous && cfg_enable, else IDLE.
- Latency, empty FIFO, n=0:
  - out_valid rises in cycle 2C(D+1)+2 after the IDLE cycle that sampled cfg_start.
  - Conversion period is 2C(D+1)+1 cycles.
- cfg_enable low in CONVERT or ACCUM:
  - Next state is IDLE; adc_clock goes low on the next edge.
  - Accumulator and counters are cleared; FIFO contents are kept.
- FIFO (first-word fall-through):
  - Pop when out_valid && out_ready.
  - Push while full with no simultaneous pop: entry dropped and overflow set.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored (out_valid was 0).
- Overflow register: set has priority over ovf_clear in the same cycle.
- cfg_start in CONVERT or ACCUM: ignored.

Decomposition:
- Shared package `adc_seq_pkg` holds:
  - State enum {IDLE, CONVERT, ACCUM}.
  - MIN_CONV_CYCLES=2, ACC_W=DATA_W+AVG_MAX_LOG2, FIFO count width.
- One sub-module: `adc_seq_fifo`, a synchronous first-word-fall-through FIFO with count output, parameterized by DATA_W and FIFO_DEPTH.

Test Plan:
- Single shot: D=1, C=9, n=0, adc_data=0xA5, start pulse at cycle 0 → adc_clock period 4 cycles with 9 rising edges; out_valid=1 with out_bits=0xA5 at cycle 38; busy low from cycle 38.
- Averaging: D=0, C=2, n=2, adc_data stepping 10, 20, 30, 41 per conversion → one push of 0x19 (101>>2=25); exactly 4 conversions, each 5 cycles apart.
- Overflow: continuous mode, out_ready=0, 5 results → fifo_count=4, overflow=1, head=first result. Pulse ovf_clear → overflow=0. Next push while popping → no overflow, count stays 4.
- Abort: drop cfg_enable mid-CONVERT (after 3 toggles) → IDLE next cycle, adc_clock=0, no push. Restart → correct result with a full 2C(D+1)+2 latency.
- Reset mid-burst: assert reset low for 1 cycle during ACCUM with 2 FIFO entries → all outputs at reset values, fifo_count=0.
- Config shadowing: change cfg_clk_div from 1 to 3 mid-burst → current burst keeps period 4; next burst uses period 8.
